sv32_ptw: RTL

SV32_PTW -- requirements
Module: sv32_ptw

---
 rtl/sv32_pkg.sv | 40 ++++
 rtl/sv32_pte_decode.sv | 18 +
 rtl/sv32_ptw.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/sv32_pkg.sv
// Sv32 page-table walker shared definitions: PTE layout, walker states,
// and the PTE address helper used by both walk levels.
package sv32_pkg;

    localparam int PAGE_SHIFT = 12;
    localparam int LEVELS     = 2;

    // PTE flag bit positions
    localparam int PTE_V = 0;
    localparam int PTE_R = 1;
    localparam int PTE_W = 2;
    localparam int PTE_X = 3;
    localparam int PTE_U = 4;
    localparam int PTE_G = 5;
    localparam int PTE_A = 6;
    localparam int PTE_D = 7;

    // PPN field slices inside a PTE
    localparam int PTE_PPN_LSB  = 10;
    localparam int PTE_PPN_MSB  = 31;
    localparam int PTE_PPN0_LSB = 10;
    localparam int PTE_PPN0_MSB = 19;
    localparam int PTE_PPN1_LSB = 20;
    localparam int PTE_PPN1_MSB = 31;

    typedef enum logic [2:0] {
        IDLE,
        L1_RD,
        L0_RD,
        FILL,
        ERR
    } ptw_state_e;

    // Physical address of a PTE: table base PPN, VPN slice, 4-byte entries
    function automatic logic [33:0] pte_addr(input logic [21:0] ppn,
                                             input logic [9:0]  vpn_sel);
        return {ppn, vpn_sel, 2'b00};
    endfunction

endpackage

// File: rtl/sv32_pte_decode.sv
// Sv32 PTE classifier: fault / leaf / pointer, plus superpage alignment.
module sv32_pte_decode
    import sv32_pkg::*;
(
    input  logic [31:0] pte,
    output logic        is_fault,
    output logic        is_leaf,
    output logic        misaligned
);

    // Invalid or write-without-read encodings fault; R or X marks a leaf
    always_comb begin
        is_fault   = !pte[PTE_V] || (!pte[PTE_R] && pte[PTE_W]);
        is_leaf    = !is_fault && (pte[PTE_R] || pte[PTE_X]);
        misaligned = (pte[PTE_PPN0_MSB:PTE_PPN0_LSB] != '0);
    end

endmodule

// File: rtl/sv32_ptw.sv
// Sv32 two-level hardware page-table walker with TLB fill port.
// Define SV32_PTW_SUPERPAGE_EN to accept level-1 leaves (4 MiB superpages);
// without it every level-1 leaf is reported as a page fault.
module sv32_ptw
    import sv32_pkg::*;
#(
    parameter int TLB_ADDR_WIDTH = 6,
    parameter int PADDR_WIDTH    = 34
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [31:0]               req_vaddr,
    input  logic                      req_store,
    input  logic [21:0]               satp_ppn,
    output logic                      mem_valid,
    input  logic                      mem_ready,
    output logic [PADDR_WIDTH-1:0]    mem_addr,
    input  logic [31:0]               mem_rdata,
    output logic                      tlb_we,
    output logic                      tlb_valid,
    output logic [TLB_ADDR_WIDTH-1:0] tlb_idx,
    output logic [19:0]               tlb_tag,
    output logic [31:0]               tlb_payload,
    output logic                      done,
    output logic                      fault
);

`ifdef SV32_PTW_SUPERPAGE_EN
    localparam bit SP_EN = 1'b1;
`else
    localparam bit SP_EN = 1'b0;
`endif

    ptw_state_e                state_q;
    logic [19:0]               vpn_q;
    logic                      store_q;
    logic                      mem_valid_q;
    logic [PADDR_WIDTH-1:0]    mem_addr_q;
    logic                      tlb_we_q;
    logic                      tlb_valid_q;
    logic [TLB_ADDR_WIDTH-1:0] tlb_idx_q;
    logic [19:0]               tlb_tag_q;
    logic [31:0]               tlb_payload_q;
    logic                      done_q;
    logic                      fault_q;

    logic        dec_fault;
    logic        dec_leaf;
    logic        dec_misaligned;
    logic        leaf_ok;
    logic        sp_ok;
    logic [31:0] sp_payload;

    sv32_pte_decode u_dec (
        .pte        (mem_rdata),
        .is_fault   (dec_fault),
        .is_leaf    (dec_leaf),
        .misaligned (dec_misaligned)
    );

    // Leaf permission check (no hardware A/D update) and superpage fill data
    always_comb begin
        leaf_ok    = mem_rdata[PTE_A] && (!store_q || mem_rdata[PTE_D]);
        sp_ok      = SP_EN && !dec_misaligned && leaf_ok;
        sp_payload = {mem_rdata[PTE_PPN1_MSB:PTE_PPN1_LSB], vpn_q[9:0],
                      mem_rdata[PTE_PPN0_LSB-1:0]};
    end

    assign req_ready   = (state_q == IDLE);
    assign mem_valid   = mem_valid_q;
    assign mem_addr    = mem_addr_q;
    assign tlb_we      = tlb_we_q;
    assign tlb_valid   = tlb_valid_q;
    assign tlb_idx     = tlb_idx_q;
    assign tlb_tag     = tlb_tag_q;
    assign tlb_payload = tlb_payload_q;
    assign done        = done_q;
    assign fault       = fault_q;

    // Walk FSM; done/fault/tlb_we are one-cycle pulses set on entry to FILL/ERR.
    // satp_ppn is captured directly into the level-1 PTE address register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            vpn_q         <= '0;
            store_q       <= 1'b0;
            mem_valid_q   <= 1'b0;
            mem_addr_q    <= '0;
            tlb_we_q      <= 1'b0;
            tlb_valid_q   <= 1'b0;
            tlb_idx_q     <= '0;
            tlb_tag_q     <= '0;
            tlb_payload_q <= '0;
            done_q        <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            tlb_we_q    <= 1'b0;
            tlb_valid_q <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        vpn_q       <= req_vaddr[31:PAGE_SHIFT];
                        store_q     <= req_store;
                        mem_addr_q  <= PADDR_WIDTH'(pte_addr(satp_ppn, req_vaddr[31:22]));
                        mem_valid_q <= 1'b1;
                        state_q     <= L1_RD;
                    end
                end
                L1_RD: begin
                    if (mem_ready) begin
                        mem_valid_q <= 1'b0;
                        if (!dec_fault && !dec_leaf) begin
                            mem_addr_q  <= PADDR_WIDTH'(pte_addr(
                                           mem_rdata[PTE_PPN_MSB:PTE_PPN_LSB], vpn_q[9:0]));
                            mem_valid_q <= 1'b1;
                            state_q     <= L0_RD;
                        end else if (dec_leaf && sp_ok) begin
                            tlb_we_q      <= 1'b1;
                            tlb_valid_q   <= 1'b1;
                            done_q        <= 1'b1;
                            tlb_tag_q     <= vpn_q;
                            tlb_idx_q     <= vpn_q[TLB_ADDR_WIDTH-1:0];
                            tlb_payload_q <= sp_payload;
                            state_q       <= FILL;
                        end else begin
                            done_q  <= 1'b1;
                            fault_q <= 1'b1;
                            state_q <= ERR;
                        end
                    end
                end
                L0_RD: begin
                    if (mem_ready) begin
                        mem_valid_q <= 1'b0;
                        if (dec_leaf && leaf_ok) begin
                            tlb_we_q      <= 1'b1;
                            tlb_valid_q   <= 1'b1;
                            done_q        <= 1'b1;
                            tlb_tag_q     <= vpn_q;
                            tlb_idx_q     <= vpn_q[TLB_ADDR_WIDTH-1:0];
                            tlb_payload_q <= mem_rdata;
                            state_q       <= FILL;
                        end else begin
                            done_q  <= 1'b1;
                            fault_q <= 1'b1;
                            state_q <= ERR;
                        end
                    end
                end
                FILL:    state_q <= IDLE;
                ERR:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
